debug_sweep_reader: RTL and testbench

//  Host-side reader for the DebugUnit select/observe interface. Drives DebugSel, waits for the
//  mux output to settle, captures DebugOutput and streams (sel, data) beats to a host over a

---
 rtl/debug_sweep_reader.sv | 150 +++++++++++++++
 tb/tb_debug_sweep_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_sweep_reader.sv
// Host-side sweep/single reader for the DebugUnit select/observe port; streams (sel, data) beats.
// Optional macro DEBUG_SWEEP_FREEZE_EN drives cpu_stall for the whole request.
module debug_sweep_reader #(
    parameter int unsigned NUM_SEL = 29,
    parameter int unsigned SEL_W   = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SETTLE  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              single_mode,
    input  logic [SEL_W-1:0]  single_sel,
    output logic [SEL_W-1:0]  DebugSel,
    input  logic [DATA_W-1:0] DebugOutput,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              cpu_stall
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_EMIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic [SEL_W-1:0]    dsel_q, dsel_d;
    logic                valid_q, valid_d;
    logic [SEL_W-1:0]    osel_q, osel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next-state and output-register update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dsel_d  = dsel_q;
        valid_d = valid_q;
        osel_d  = osel_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = single_mode ? single_sel : '0;
                    dsel_d  = single_mode ? single_sel : '0;
                    mode_d  = single_mode;
                    cnt_d   = CNT_W'(SETTLE - 1);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    data_d  = DebugOutput;
                    osel_d  = idx_q;
                    last_d  = mode_q | (idx_q == SEL_W'(NUM_SEL - 1));
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + SEL_W'(1);
                        dsel_d  = idx_q + SEL_W'(1);
                        cnt_d   = CNT_W'(SETTLE - 1);
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_SETTLE) || (state_d == S_EMIT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            dsel_q  <= '0;
            valid_q <= 1'b0;
            osel_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dsel_q  <= dsel_d;
            valid_q <= valid_d;
            osel_q  <= osel_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef DEBUG_SWEEP_FREEZE_EN
    // Hold the core from the cycle after start through the DONE cycle
    logic stall_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= (state_d != S_IDLE);
        end
    end
    assign cpu_stall = stall_q;
`else
    assign cpu_stall = 1'b0;
`endif

    assign DebugSel  = dsel_q;
    assign out_valid = valid_q;
    assign out_sel   = osel_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_debug_sweep_reader.sv
// Scoreboard bench for debug_sweep_reader: random debug words, random back-pressure and start noise.
`timescale 1ns/1ps
module tb_debug_sweep_reader;

    localparam int unsigned NUM_SEL = 29;
    localparam int unsigned SETTLE  = 1;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, start, single_mode, out_ready;
    logic [4:0]  single_sel, dbg_sel, out_sel;
    logic [31:0] dbg_out, out_data;
    logic        out_valid, out_last, busy, done, cpu_stall;

    logic [31:0] mem [32];
    assign dbg_out = mem[dbg_sel];

    debug_sweep_reader #(.NUM_SEL(NUM_SEL), .SEL_W(5), .DATA_W(32), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .start(start), .single_mode(single_mode),
        .single_sel(single_sel), .DebugSel(dbg_sel), .DebugOutput(dbg_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
        .cpu_stall(cpu_stall)
    );

    always #5 clk = ~clk;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    beat_t exp_q[$];
    bit    in_req = 1'b0;
    bit    full_ready = 1'b0;
    int    e0_cyc = 0;
    int    done_seen = 0;

    bit    tail = 1'b0;
    bit    hold = 1'b0;
    logic [4:0]  hold_sel;
    logic [31:0] hold_data;
    int    hs_idx = 0;
    int    last_hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: protocol checks and scoreboard pop on every handshake
    always @(negedge clk) begin
        if (reset) begin
            tail = 1'b0;
            hold = 1'b0;
            hs_idx = 0;
        end else begin
            beat_t e;
            chk("done", 64'(done), 64'(tail));
            chk("busy", 64'(busy), 64'(in_req && !tail));
`ifdef DEBUG_SWEEP_FREEZE_EN
            chk("cpu_stall", 64'(cpu_stall), 64'(in_req));
`else
            chk("cpu_stall", 64'(cpu_stall), 64'd0);
`endif
            if (tail) begin
                tail = 1'b0;
                hs_idx = 0;
                done_seen++;
            end
            if (out_valid) begin
                chk("valid_in_request", 64'(in_req), 64'd1);
                chk("debugsel_held", 64'(dbg_sel), 64'(out_sel));
            end
            if (hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_sel", 64'(out_sel), 64'(hold_sel));
                chk("hold_data", 64'(out_data), 64'(hold_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(out_sel), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_sel", 64'(out_sel), 64'(e.sel));
                    chk("beat_data", 64'(out_data), 64'(e.data));
                    chk("beat_last", 64'(out_last), 64'(e.last));
                    if (full_ready) begin
                        if (hs_idx == 0) chk("first_latency", 64'(cyc - e0_cyc), 64'(SETTLE));
                        else             chk("beat_gap", 64'(cyc - last_hs_cyc), 64'(SETTLE + 1));
                    end
                    if (e.last) tail = 1'b1;
                end
                hs_idx++;
                last_hs_cyc = cyc;
            end
            hold = out_valid && !out_ready;
            hold_sel = out_sel;
            hold_data = out_data;
        end
    end

    task automatic do_reset();
        in_req = 1'b0;
        full_ready = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // rmode: 0 ready high, 1 random ready, 2 stall 5 cycles on sel 3, 3 reset during EMIT of sel 7
    task automatic run_req(input bit single, input logic [4:0] ssel, input int rmode, input bit noise);
        int snap;
        int hold_cnt;
        bit fin;
        beat_t b;
        snap = done_seen;
        hold_cnt = 0;
        fin = 1'b0;
        if (single) begin
            b.sel = ssel; b.data = mem[ssel]; b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int i = 0; i < int'(NUM_SEL); i++) begin
                b.sel = 5'(i); b.data = mem[i]; b.last = (i == int'(NUM_SEL) - 1);
                exp_q.push_back(b);
            end
        end
        @(posedge clk); #1;
        start = 1'b1; single_mode = single; single_sel = ssel; out_ready = 1'b1;
        @(posedge clk); #1;
        in_req = 1'b1; e0_cyc = cyc; full_ready = (rmode == 0); start = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (done_seen != snap) begin
                fin = 1'b1;
                break;
            end
            if (rmode == 3 && out_valid && out_sel == 5'd7) begin
                out_ready = 1'b0;
                in_req = 1'b0;
                exp_q.delete();
                reset = 1'b1;
                @(posedge clk); #1;
                chk("abort_valid", 64'(out_valid), 64'd0);
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_debugsel", 64'(dbg_sel), 64'd0);
                chk("abort_done", 64'(done), 64'd0);
                chk("abort_stall", 64'(cpu_stall), 64'd0);
                @(posedge clk); #1 reset = 1'b0;
                out_ready = 1'b1;
                fin = 1'b1;
                break;
            end
            case (rmode)
                1: out_ready = ($urandom_range(2) != 0);
                2: if (out_valid && out_sel == 5'd3 && hold_cnt < 5) begin
                       out_ready = 1'b0;
                       hold_cnt++;
                   end else begin
                       out_ready = 1'b1;
                   end
                default: out_ready = 1'b1;
            endcase
            if (noise) begin
                start = done ? 1'b1 : ($urandom_range(4) == 0);
                single_mode = 1'($urandom);
                single_sel = 5'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        in_req = 1'b0;
        full_ready = 1'b0;
        if (!fin) begin
            chk("request_timeout", 64'd0, 64'd1);
            do_reset();
        end
        if (rmode == 2) chk("hold_cycles_applied", 64'(hold_cnt), 64'd5);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; single_mode = 1'b0; single_sel = '0; out_ready = 1'b0;
        fill_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_debugsel", 64'(dbg_sel), 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_req(1'b0, 5'd0, 0, 1'b0);
        mem[13] = 32'h0000_01A4;
        run_req(1'b1, 5'd13, 0, 1'b0);
        fill_mem();
        run_req(1'b0, 5'd0, 2, 1'b1);
        for (int k = 0; k < 6; k++) begin
            fill_mem();
            run_req(1'($urandom), 5'($urandom), $urandom_range(1), 1'b1);
        end
        run_req(1'b1, 5'd31, 1, 1'b0);
        fill_mem();
        run_req(1'b0, 5'd0, 3, 1'b0);
        run_req(1'b1, 5'd28, 0, 1'b1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
